// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Supports fixed priority with a starvation guard, or round-robin.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rr_mode,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_sel,
  output logic              m0_gnt,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_sel,
  output logic              m1_gnt,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,

  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_sel,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } owner_t;

  owner_t      r_last;
  owner_t      w_last_next;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_next;
  logic        r_rd_m0;
  logic        r_rd_m1;
  logic        w_gnt0;
  logic        w_gnt1;

  // Grant decision; reset forces both grants low regardless of requests.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (rr_mode) begin
          if (r_last == LAST_M1) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b1;
          end
        end else if (r_starve_cnt == STARVE_LIM) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = 1'b1;
        end
      end else if (m0_req) begin
        w_gnt0 = 1'b1;
      end else if (m1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // Next-state logic: both the starvation counter and the last owner run in
  // either mode so a mode switch picks up consistent history.
  always_comb begin
    w_starve_next = r_starve_cnt;
    w_last_next   = r_last;
    if (!m1_req || w_gnt1) begin
      w_starve_next = 4'd0;
    end else if (w_gnt0 && (r_starve_cnt < STARVE_LIM)) begin
      w_starve_next = r_starve_cnt + 4'd1;
    end
    if (w_gnt0) begin
      w_last_next = LAST_M0;
    end else if (w_gnt1) begin
      w_last_next = LAST_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
      r_last       <= LAST_M1;
      r_rd_m0      <= 1'b0;
      r_rd_m1      <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_last       <= w_last_next;
      r_rd_m0      <= w_gnt0 && !m0_we;
      r_rd_m1      <= w_gnt1 && !m1_we;
    end
  end

  // RAM port mux; idle cycles drive all-zero fields.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_sel   = '0;
    if (w_gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_sel   = m0_sel;
    end else if (w_gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_sel   = m1_sel;
    end
  end

  assign ram_ce = w_gnt0 | w_gnt1;
  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  // Read returns are masked during reset so an in-flight read is dropped.
  assign m0_rvalid = r_rd_m0 & ~rst;
  assign m1_rvalid = r_rd_m1 & ~rst;
  assign m0_rdata  = m0_rvalid ? ram_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural RAM plus expected read
// returns queued with the cycle they are due.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rr_mode;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rr_mode(rr_mode),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sel(m0_sel), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata)
  );

  // Unwritten locations return an address-derived pattern; 0x10 holds 0xDEADBEEF.
  function automatic logic [31:0] rom(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {8'hC0, a, ~a, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mem [256];
  bit          written [256];

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        mem[ram_addr[7:0]]     <= merge(written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : rom(ram_addr[7:0]),
                                        ram_wdata, ram_sel);
        written[ram_addr[7:0]] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : rom(ram_addr[7:0]);
      end
    end
  end

  typedef struct {
    bit          m1;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_sel = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_sel = 0;
  endtask

  task automatic push_read(input bit m1, input logic [31:0] data);
    exp_t e;
    e.m1 = m1; e.data = data; e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Advance to the falling edge and check read-return outputs against the queue.
  task automatic sample();
    exp_t e;
    bit   ok;
    @(negedge clk);
    cyc++;
    tests++;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.m1) ok = (m1_rvalid === 1'b1) && (m1_rdata === e.data) && (m0_rvalid === 1'b0);
      else      ok = (m0_rvalid === 1'b1) && (m0_rdata === e.data) && (m1_rvalid === 1'b0);
      if (e.due != cyc || !ok) begin
        fails++;
        $display("FAIL rvalid_m%0d cyc %0d: got rv0=%b rd0=%h rv1=%b rd1=%h, expected rvalid on m%0d data=%h due cyc %0d",
                 e.m1, cyc, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, e.m1, e.data, e.due);
      end
    end else if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'd0) begin
      fails++;
      $display("FAIL rvalid_idle cyc %0d: got rv0=%b rd0=%h rv1=%b rd1=%h, expected all 0",
               cyc, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; m0_req = 1; m1_req = 1; m0_addr = 32'h44; m1_addr = 32'h88;
    m0_we = 1; m0_wdata = 32'hFFFF_FFFF; m0_sel = 4'hF;
    sample();
    tests++;
    if ({m0_gnt, m1_gnt, ram_ce} !== 3'b000) begin
      fails++;
      $display("FAIL reset_grants: got gnt0=%b gnt1=%b ce=%b, expected 000", m0_gnt, m1_gnt, ram_ce);
    end
    tests++;
    if ({ram_we, ram_addr, ram_wdata, ram_sel} !== 69'd0) begin
      fails++;
      $display("FAIL reset_ram_fields: got we=%b addr=%h wdata=%h sel=%h, expected 0",
               ram_we, ram_addr, ram_wdata, ram_sel);
    end
    step();
    rst = 0;
    set_idle();
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 2; i++) begin
      sample();
      step();
    end
  endtask

  task automatic test_fixed_read();
    rr_mode = 0; set_idle();
    m0_req = 1; m0_addr = 32'h10; m0_sel = 4'hF;
    sample();
    tests++;
    if ({m0_gnt, m1_gnt, ram_ce, ram_we} !== 4'b1010 || ram_addr !== 32'h10 || ram_sel !== 4'hF) begin
      fails++;
      $display("FAIL fixed_read_grant: got gnt0=%b gnt1=%b ce=%b we=%b addr=%h sel=%h, expected 1 0 1 0 00000010 f",
               m0_gnt, m1_gnt, ram_ce, ram_we, ram_addr, ram_sel);
    end
    push_read(1'b0, 32'hDEADBEEF);
    step();
    drain();
  endtask

  task automatic test_starvation();
    bit exp1;
    rr_mode = 0; set_idle();
    m0_req = 1; m0_addr = 32'h40; m0_sel = 4'hF;
    m1_req = 1; m1_addr = 32'h80; m1_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      exp1 = (i % 5) == 4;
      sample();
      tests++;
      if (m0_gnt !== !exp1 || m1_gnt !== exp1 || ram_addr !== (exp1 ? 32'h80 : 32'h40)) begin
        fails++;
        $display("FAIL starve_pattern[%0d]: got gnt0=%b gnt1=%b addr=%h, expected gnt1=%b",
                 i, m0_gnt, m1_gnt, ram_addr, exp1);
      end
      push_read(exp1, rom(exp1 ? 8'h80 : 8'h40));
      step();
    end
    drain();
  endtask

  task automatic reset_pulse();
    set_idle();
    rst = 1;
    sample();
    step();
    rst = 0;
  endtask

  task automatic test_round_robin();
    bit exp1;
    reset_pulse();
    rr_mode = 1;
    m0_req = 1; m0_addr = 32'h44; m0_sel = 4'hF;
    m1_req = 1; m1_addr = 32'h84; m1_sel = 4'hF;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) m1_req = 0;
      exp1 = (i < 6) && (i % 2 == 1);
      sample();
      tests++;
      if (m0_gnt !== !exp1 || m1_gnt !== exp1) begin
        fails++;
        $display("FAIL rr_pattern[%0d]: got gnt0=%b gnt1=%b, expected gnt0=%b gnt1=%b",
                 i, m0_gnt, m1_gnt, !exp1, exp1);
      end
      push_read(exp1, rom(exp1 ? 8'h84 : 8'h44));
      step();
    end
    drain();
  endtask

  task automatic test_write_then_read();
    rr_mode = 0; set_idle();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_sel = 4'b0011;
    sample();
    tests++;
    if ({m0_gnt, m1_gnt, ram_ce, ram_we} !== 4'b0111 || ram_addr !== 32'h20 ||
        ram_wdata !== 32'h12345678 || ram_sel !== 4'b0011) begin
      fails++;
      $display("FAIL write_fields: got gnt0=%b gnt1=%b ce=%b we=%b addr=%h wdata=%h sel=%b, expected 0 1 1 1 00000020 12345678 0011",
               m0_gnt, m1_gnt, ram_ce, ram_we, ram_addr, ram_wdata, ram_sel);
    end
    step();
    set_idle();
    m0_req = 1; m0_addr = 32'h20; m0_sel = 4'hF;
    sample();
    tests++;
    if (m0_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h20) begin
      fails++;
      $display("FAIL read_after_write_grant: got gnt0=%b we=%b addr=%h, expected 1 0 00000020",
               m0_gnt, ram_we, ram_addr);
    end
    push_read(1'b0, 32'hC0205678);
    step();
    drain();
  endtask

  task automatic test_back_to_back();
    rr_mode = 0; set_idle();
    m0_req = 1; m0_addr = 32'h30; m0_sel = 4'hF;
    sample();
    tests++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL b2b_m0_grant: got gnt0=%b gnt1=%b, expected 1 0", m0_gnt, m1_gnt);
    end
    push_read(1'b0, rom(8'h30));
    step();
    set_idle();
    m1_req = 1; m1_addr = 32'h34; m1_sel = 4'hF;
    sample();
    tests++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || ram_addr !== 32'h34) begin
      fails++;
      $display("FAIL b2b_m1_grant: got gnt0=%b gnt1=%b addr=%h, expected 0 1 00000034",
               m0_gnt, m1_gnt, ram_addr);
    end
    push_read(1'b1, rom(8'h34));
    step();
    drain();
  endtask

  task automatic test_reset_mid_read();
    rr_mode = 1; set_idle();
    m0_req = 1; m0_addr = 32'h50; m0_sel = 4'hF;
    sample();
    tests++;
    if (m0_gnt !== 1'b1) begin
      fails++;
      $display("FAIL midrst_grant: got gnt0=%b, expected 1", m0_gnt);
    end
    step();
    rst = 1;
    m1_req = 1; m1_addr = 32'h70;
    sample();
    tests++;
    if ({m0_gnt, m1_gnt, ram_ce} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_outputs: got gnt0=%b gnt1=%b ce=%b, expected 000", m0_gnt, m1_gnt, ram_ce);
    end
    step();
    rst = 0;
    m0_addr = 32'h60; m1_sel = 4'hF;
    for (int i = 0; i < 2; i++) begin
      sample();
      tests++;
      if (m0_gnt !== (i == 0) || m1_gnt !== (i == 1)) begin
        fails++;
        $display("FAIL midrst_rr[%0d]: got gnt0=%b gnt1=%b, expected gnt0=%b", i, m0_gnt, m1_gnt, i == 0);
      end
      push_read(i == 1, rom(i == 1 ? 8'h70 : 8'h60));
      step();
    end
    drain();
  endtask

  initial begin
    rst = 1; rr_mode = 0;
    set_idle();
    step();
    test_reset();
    test_fixed_read();
    test_starvation();
    test_round_robin();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d pending reads, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
